// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared helpers and types for the CIC compensation FIR
package cic_comp_pkg;

  // Working width for round/saturate; comfortably wider than any legal ACC_DW+1
  localparam int RS_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int inp_dw, input int coef_dw, input int taps);
    return inp_dw + coef_dw + clog2(taps);
  endfunction

  // Round half-up by adding 2^(shift-1), arithmetic shift, then clamp to out_dw signed range.
  // Done at RS_W bits so the rounding add can never wrap.
  function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] acc,
                                                       input int shift, input int out_dw);
    logic signed [RS_W-1:0] one, v, hi, lo;
    one = {{(RS_W-1){1'b0}}, 1'b1};
    v   = acc;
    if (shift > 0) v = v + (one <<< (shift - 1));
    v  = v >>> shift;
    hi = (one <<< (out_dw - 1)) - one;
    lo = -(one <<< (out_dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/cic_comp_fir_mac.sv
// rtl/cic_comp_fir_mac.sv - signed multiply-accumulate with clear and enable
module cic_comp_fir_mac #(
  parameter int A_DW   = 32,
  parameter int B_DW   = 18,
  parameter int ACC_DW = 54
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [A_DW-1:0]   a,
  input  logic signed [B_DW-1:0]   b,
  output logic signed [ACC_DW-1:0] acc
);

  logic signed [A_DW+B_DW-1:0] prod;
  logic signed [ACC_DW-1:0]    prod_ext;
  logic signed [ACC_DW-1:0]    acc_d, acc_q;

  // Full-precision product; clear restarts the sum with the current product
  always_comb begin
    prod     = $signed({{B_DW{a[A_DW-1]}}, a}) * $signed({{A_DW{b[B_DW-1]}}, b});
    prod_ext = {{(ACC_DW-A_DW-B_DW){prod[A_DW+B_DW-1]}}, prod};
    acc_d    = acc_q;
    if (en) acc_d = (clear ? '0 : acc_q) + prod_ext;
    else if (clear) acc_d = '0;
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - sequential-MAC compensation FIR behind a CIC decimator
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int                          INP_DW    = 32,
  parameter int                          OUT_DW    = 32,
  parameter int                          COEF_DW   = 18,
  parameter int                          NUM_TAPS  = 16,
  parameter logic [COEF_DW*NUM_TAPS-1:0] COEFS     = '0,
  parameter int                          DECIM     = 2,
  parameter int                          OUT_SHIFT = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INP_DW-1:0] s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic              overrun
);

  localparam int ACC_DW = acc_width(INP_DW, COEF_DW, NUM_TAPS);
  localparam int TAP_W  = clog2(NUM_TAPS);

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic               phase_q, phase_d;
  logic [INP_DW-1:0]  x_q [NUM_TAPS];
  logic [INP_DW-1:0]  x_d [NUM_TAPS];
  logic [OUT_DW-1:0]  out_q, out_d;
  logic               vld_q, vld_d;
  logic               ovr_q, ovr_d;
  logic               mac_clear, mac_en;
  logic [COEF_DW-1:0] coef;
  logic signed [ACC_DW-1:0] acc;
  logic signed [RS_W-1:0]   acc_ext;

  // Tap selection feeding the MAC and sign extension of the accumulator for rounding
  always_comb begin
    coef    = COEFS[COEF_DW*int'(tap_q) +: COEF_DW];
    acc_ext = {{(RS_W-ACC_DW){acc[ACC_DW-1]}}, acc};
  end

  cic_comp_fir_mac #(
    .A_DW  (INP_DW),
    .B_DW  (COEF_DW),
    .ACC_DW(ACC_DW)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clear(mac_clear),
    .en   (mac_en),
    .a    ($signed(x_q[tap_q])),
    .b    ($signed(coef)),
    .acc  (acc)
  );

  // FSM next-state: accept samples in IDLE, one tap per MAC cycle, round/saturate in OUT
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    phase_d   = phase_q;
    x_d       = x_q;
    out_d     = out_q;
    vld_d     = 1'b0;
    ovr_d     = ovr_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_in_tvalid) begin
          x_d[0] = s_axis_in_tdata;
          for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
          if (DECIM == 1 || phase_q) begin
            phase_d = 1'b0;
            tap_d   = '0;
            state_d = ST_MAC;
          end else begin
            phase_d = 1'b1;
          end
        end
      end
      ST_MAC: begin
        mac_en    = 1'b1;
        mac_clear = (tap_q == '0);
        if (tap_q == TAP_W'(NUM_TAPS - 1)) state_d = ST_OUT;
        else tap_d = tap_q + 1'b1;
        if (s_axis_in_tvalid) ovr_d = 1'b1;
      end
      ST_OUT: begin
        out_d   = OUT_DW'(round_sat(acc_ext, OUT_SHIFT, OUT_DW));
        vld_d   = 1'b1;
        state_d = ST_IDLE;
        if (s_axis_in_tvalid) ovr_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, delay line and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      phase_q <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_axis_out_tdata  = out_q;
  assign m_axis_out_tvalid = vld_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - directed self-checking bench for cic_comp_fir
module tb_cic_comp_fir;

  localparam int N  = 16;
  localparam int CW = 18;

  function automatic logic [CW*N-1:0] fill(input int mode);
    logic [CW*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       r[CW*k +: CW] = CW'(k + 1);
        1:       r[CW*k +: CW] = CW'(65536);
        default: r[CW*k +: CW] = CW'(131071);
      endcase
    end
    return r;
  endfunction

  localparam logic [CW*N-1:0] COEFS_A = fill(0);
  localparam logic [CW*N-1:0] COEFS_B = fill(1);
  localparam logic [CW*N-1:0] COEFS_C = fill(2);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din [3];
  logic        vin [3];
  logic [31:0] a_od, b_od;
  logic [15:0] c_od;
  logic        a_ov, b_ov, c_ov;
  logic        a_ovr, b_ovr, c_ovr;
  int          cyc = 0;
  int          t_send = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comp_fir #(.INP_DW(32), .OUT_DW(32), .COEF_DW(CW), .NUM_TAPS(N), .COEFS(COEFS_A),
                 .DECIM(1), .OUT_SHIFT(0)) u_a (
    .clk(clk), .reset(reset), .s_axis_in_tdata(din[0]), .s_axis_in_tvalid(vin[0]),
    .m_axis_out_tdata(a_od), .m_axis_out_tvalid(a_ov), .overrun(a_ovr));

  cic_comp_fir #(.INP_DW(32), .OUT_DW(32), .COEF_DW(CW), .NUM_TAPS(N), .COEFS(COEFS_B),
                 .DECIM(2), .OUT_SHIFT(17)) u_b (
    .clk(clk), .reset(reset), .s_axis_in_tdata(din[1]), .s_axis_in_tvalid(vin[1]),
    .m_axis_out_tdata(b_od), .m_axis_out_tvalid(b_ov), .overrun(b_ovr));

  cic_comp_fir #(.INP_DW(32), .OUT_DW(16), .COEF_DW(CW), .NUM_TAPS(N), .COEFS(COEFS_C),
                 .DECIM(1), .OUT_SHIFT(0)) u_c (
    .clk(clk), .reset(reset), .s_axis_in_tdata(din[2]), .s_axis_in_tvalid(vin[2]),
    .m_axis_out_tdata(c_od), .m_axis_out_tvalid(c_ov), .overrun(c_ovr));

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic out_v(input int i);
    case (i)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic longint out_d(input int i);
    case (i)
      0:       return longint'($signed(a_od));
      1:       return longint'($signed(b_od));
      default: return longint'($signed(c_od));
    endcase
  endfunction

  task automatic send(input int i, input longint d);
    din[i] = d[31:0];
    vin[i] = 1'b1;
    t_send = cyc;
    @(posedge clk); #1;
    vin[i] = 1'b0;
  endtask

  task automatic wait_out(input int i, input longint exp, input string tag);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_v(i)) begin
        check(tag, out_d(i), exp);
        check({tag, "_lat"}, longint'(cyc - t_send), longint'(N + 2));
        return;
      end
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic quiet(input int i, input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (out_v(i)) seen++;
    end
    check(tag, longint'(seen), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_impulse(input string tag);
    for (int s = 0; s < N; s++) begin
      send(0, (s == 0) ? 64'sd1000 : 64'sd0);
      wait_out(0, longint'((s + 1) * 1000), $sformatf("%s%0d", tag, s));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      vin[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_tdata", longint'(a_od), 0);
    check("rst_tvalid", longint'(a_ov), 0);
    check("rst_overrun", longint'(a_ovr), 0);
    check("rst_c_tdata", longint'(c_od), 0);

    run_impulse("imp");
    check("imp_no_overrun", longint'(a_ovr), 0);

    do_reset();
    send(0, 1000);
    repeat (4) begin
      @(posedge clk); #1;
    end
    din[0] = 32'd7;
    vin[0] = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    check("ovr_flag", longint'(a_ovr), 1);
    wait_out(0, 1000, "ovr_out");
    quiet(0, 30, "ovr_single");
    check("ovr_sticky", longint'(a_ovr), 1);

    do_reset();
    send(0, 1000);
    repeat (7) begin
      @(posedge clk); #1;
    end
    do_reset();
    quiet(0, 30, "rst_mid_mac");
    check("rst_mid_tdata", longint'(a_od), 0);
    check("rst_mid_overrun", longint'(a_ovr), 0);
    run_impulse("rimp");

    for (int s = 0; s < 2 * N; s++) begin
      send(1, 100);
      if (s % 2 == 1) wait_out(1, longint'((((s + 1) / 2) < 8 ? ((s + 1) / 2) : 8) * 100),
                               $sformatf("dc%0d", s));
      else quiet(1, 3, $sformatf("dc_skip%0d", s));
    end
    check("dc_no_overrun", longint'(b_ovr), 0);

    send(2, 64'sd2147483647);
    wait_out(2, 32767, "sat_pos");
    send(2, -64'sd2147483648);
    wait_out(2, -32768, "sat_neg");
    check("sat_no_overrun", longint'(c_ovr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 Parameter INP_DW, default 32, width of signed input samples from the CIC decimator output.
REQ-002 Parameter OUT_DW, default 32, width of signed output samples.
REQ-003 Parameter COEF_DW, default 18, width of signed coefficients.
REQ-004 Parameter NUM_TAPS, default 16, number of FIR taps; legal range 2..64.
REQ-005 Parameter COEFS, default all-zero packed vector of COEF_DW*NUM_TAPS bits; tap k is at [COEF_DW*k +: COEF_DW].
REQ-006 Parameter DECIM, default 2, output decimation ratio; legal values 1 and 2.
REQ-007 Parameter OUT_SHIFT, default 17, arithmetic right shift applied to the accumulator before rounding.
REQ-008 clk  input  1  single clock; all logic on its rising edge.
REQ-009 reset  input  1  reset, synchronous to clk and active-high.
REQ-010 s_axis_in_tdata  input  INP_DW  signed sample; connects directly to CIC m_axis_out_tdata.
REQ-011 s_axis_in_tvalid  input  1  one-cycle sample strobe; there is no ready signal.
REQ-012 m_axis_out_tdata  output  OUT_DW  signed filtered sample, held until the next output.
REQ-013 m_axis_out_tvalid  output  1  one-cycle pulse per new output.
REQ-014 overrun  output  1  sticky flag indicating at least one input sample was dropped.

Function
REQ-015 The block SHALL hold a NUM_TAPS-deep register delay line x[0..NUM_TAPS-1]; x[0] is always the newest sample.
REQ-016 FSM states SHALL be IDLE, MAC and OUT; the block leaves reset in IDLE.
REQ-017 In IDLE, tvalid=1: shift the sample into x[0] and advance the phase counter (modulo DECIM).
REQ-018 In IDLE, if that shift completes a decimation phase (counter wraps to 0; every sample when DECIM=1), the FSM SHALL go to MAC on the next cycle. Otherwise it SHALL stay in IDLE.
REQ-019 In MAC, the accumulator SHALL clear on entry, then add COEFS[k]*x[k] for k=0..NUM_TAPS-1, one product per cycle, over exactly NUM_TAPS cycles.
REQ-020 Accumulator width SHALL be ACC_DW = INP_DW+COEF_DW+clog2(NUM_TAPS), full precision, signed, with no intermediate truncation.
REQ-021 In OUT (one cycle), the result SHALL be computed as sat_OUT_DW((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT). The rounding term is omitted when OUT_SHIFT=0.
REQ-022 Saturation limits are +2^(OUT_DW-1)-1 and -2^(OUT_DW-1); the rounding addition SHALL be done at ACC_DW+1 bits so it cannot wrap.
REQ-023 The OUT result SHALL be registered to m_axis_out_tdata, with m_axis_out_tvalid=1 for exactly the following cycle, and the FSM SHALL return to IDLE.
REQ-024 Latency from the tvalid cycle of a phase-completing sample to m_axis_out_tvalid SHALL be NUM_TAPS+2 cycles.
REQ-025 In MAC or OUT, tvalid=1 SHALL drop the sample: no delay-line or phase-counter change, and overrun is set to 1.
REQ-026 overrun SHALL clear only on reset.
REQ-027 tvalid in the same cycle the FSM returns from OUT to IDLE SHALL be accepted, since the state is IDLE on the following edge.
REQ-028 Minimum loss-free input spacing SHALL be NUM_TAPS+2 cycles (DECIM=1). With DECIM=2, only phase-completing samples start a computation.

Reset
REQ-029 reset=1 at any clock edge, including mid-MAC, SHALL force IDLE and a zero phase counter, and SHALL zero the accumulator and all delay-line registers.
REQ-030 reset SHALL also clear m_axis_out_tdata, m_axis_out_tvalid and overrun to 0.
REQ-031 A computation interrupted by reset SHALL produce no output pulse.

Structure
REQ-032 Shared package cic_comp_pkg SHALL hold the clog2 function, the ACC_DW calculation function, the signed round/saturate function, and the FSM state enum type.
REQ-033 One sub-module, cic_comp_fir_mac, SHALL contain the signed multiplier and accumulator, with clear and enable inputs; the FSM, delay line and output register stay in cic_comp_fir.

Verification
REQ-034 Impulse test (DECIM=1, OUT_SHIFT=0, COEFS=1..16): input 1000 followed by 15 zeros, spaced 18 cycles apart -> outputs 1000,2000,...,16000.
REQ-035 DC test (DECIM=2, COEFS all 2^16, OUT_SHIFT=17, NUM_TAPS=16): constant input 100 -> steady-state output 800, one output per two inputs.
REQ-036 Saturation test (OUT_DW=16, OUT_SHIFT=0, COEFS all 2^17-1): input +2^31-1 -> 32767; input -2^31 -> -32768.
REQ-037 Overrun test: a second phase-completing sample arriving 5 cycles after the first -> sample dropped, overrun=1, single output equal to the model result for the first sample.
REQ-038 Reset test: reset asserted at MAC cycle 8 -> no m_axis_out_tvalid. The next impulse after reset then reproduces the REQ-034 sequence from zeroed history.
REQ-039 Latency check: for every test, m_axis_out_tvalid occurs exactly NUM_TAPS+2 cycles after the triggering tvalid.
